// File: rtl/note_sequencer.sv
// note_sequencer: walks a synchronous song ROM one entry per note.
// It presents each note's pitch and length, and advances on a rising
// edge of 'change' from the length counter. It also handles the
// end-of-song marker, optional looping, and start/stop control.
module note_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int PITCH_W = 4,
    parameter int LEN_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       change,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [PITCH_W+LEN_W:0]     rom_data,
    output logic [PITCH_W-1:0]         pitch,
    output logic [LEN_W-1:0]           length,
    output logic                       playing,
    output logic                       note_start,
    output logic                       song_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_chg_prev;

    // Decoded ROM entry fields: {end_flag, pitch, length}.
    logic               w_end;
    logic [PITCH_W-1:0] w_pitch;
    logic [LEN_W-1:0]   w_len;
    logic               w_chg_rise;

    assign w_end      = rom_data[PITCH_W+LEN_W];
    assign w_pitch    = rom_data[PITCH_W+LEN_W-1:LEN_W];
    assign w_len      = rom_data[LEN_W-1:0];
    assign w_chg_rise = change & ~r_chg_prev;

    // Sequencer FSM. All outputs are registered here. The 'change'
    // history is updated every cycle, so an edge seen outside PLAY
    // is consumed and dropped rather than queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_chg_prev <= 1'b0;
            rom_addr   <= '0;
            pitch      <= '0;
            length     <= '0;
            playing    <= 1'b0;
            note_start <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            r_chg_prev <= change;
            note_start <= 1'b0;
            song_done  <= 1'b0;
            if (r_state == S_IDLE) begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    rom_addr <= '0;
                    r_state  <= S_FETCH;
                end
            end else if (stop) begin
                r_state <= S_IDLE;
                playing <= 1'b0;
                pitch   <= '0;
            end else begin
                case (r_state)
                    S_FETCH: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (!w_end) begin
                            pitch      <= w_pitch;
                            // a zero length would stall the length counter
                            length     <= (w_len == '0) ? LEN_W'(1) : w_len;
                            playing    <= 1'b1;
                            note_start <= 1'b1;
                            r_state    <= S_PLAY;
                        end else if (loop_en) begin
                            // keep the previous note sounding while refetching entry 0
                            rom_addr <= '0;
                            r_state  <= S_FETCH;
                        end else begin
                            playing   <= 1'b0;
                            pitch     <= '0;
                            song_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_PLAY: begin
                        if (w_chg_rise) begin
                            // natural wrap at the top of the address space
                            rom_addr <= rom_addr + ADDR_W'(1);
                            r_state  <= S_FETCH;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
